// File: rtl/score_bcd_counter.sv
// score_bcd_counter: saturating two-digit BCD score with WIN blink, feeding dual_7_seg.
// Optional SCORE_LEADING_ZERO_BLANK_EN blanks a zero tens digit on the display.
module score_bcd_counter #(
    parameter int WIN_SCORE    = 21,
    parameter int BLINK_CYCLES = 5000000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       clr_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [6:0] score_o,
    output logic       win_o
);
    localparam int CW = $clog2(BLINK_CYCLES);
    localparam logic [0:0] PLAY = 1'b0, WIN = 1'b1;
    localparam logic [3:0] BLANK = 4'd10, LET_P = 4'd11;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] TENS_RST = BLANK;
`else
    localparam logic [3:0] TENS_RST = 4'd0;
`endif

    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic          inc_q, dec_q;
    logic          inc_ev, dec_ev, up_win, at_zero, at_max, wrap, blink;
    logic [3:0]    up_t, up_o, dn_t, dn_o, disp_t, disp_o;

    assign inc_ev = inc_i & ~inc_q;
    assign dec_ev = dec_i & ~dec_q;

    always_comb begin
        up_o    = ones_q == 4'd9 ? 4'd0 : ones_q + 4'd1;
        up_t    = ones_q == 4'd9 ? tens_q + 4'd1 : tens_q;
        dn_o    = ones_q == 4'd0 ? 4'd9 : ones_q - 4'd1;
        dn_t    = ones_q == 4'd0 ? tens_q - 4'd1 : tens_q;
        up_win  = 7'(up_t) * 7'd10 + 7'(up_o) == 7'(WIN_SCORE);
        at_zero = tens_q == 4'd0 && ones_q == 4'd0;
        at_max  = tens_q == 4'd9 && ones_q == 4'd9;
        wrap    = cnt_q == CW'(BLINK_CYCLES - 1);
        tens_d  = tens_q;
        ones_d  = ones_q;
        state_d = state_q;
        cnt_d   = state_q == WIN ? (wrap ? '0 : cnt_q + CW'(1)) : '0;
        phase_d = state_q == WIN ? phase_q ^ wrap : 1'b0;
        if (clr_i) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            state_d = PLAY;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (inc_ev && !dec_ev && state_q == PLAY && !at_max) begin
            tens_d = up_t;
            ones_d = up_o;
            if (up_win) begin
                state_d = WIN;
                cnt_d   = '0;
                phase_d = 1'b0;
            end
        end else if (dec_ev && !inc_ev && !at_zero) begin
            // Also the correction path out of WIN
            tens_d  = dn_t;
            ones_d  = dn_o;
            state_d = PLAY;
            cnt_d   = '0;
            phase_d = 1'b0;
        end
    end

    always_comb begin
        blink  = state_q == WIN && phase_q;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        disp_t = blink ? LET_P : (tens_q == 4'd0 ? BLANK : tens_q);
`else
        disp_t = blink ? LET_P : tens_q;
`endif
        disp_o = blink ? BLANK : ones_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            state_q <= PLAY;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            tens_o  <= TENS_RST;
            ones_o  <= 4'd0;
            score_o <= 7'd0;
            win_o   <= 1'b0;
        end else begin
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            inc_q   <= inc_i;
            dec_q   <= dec_i;
            tens_o  <= disp_t;
            ones_o  <= disp_o;
            score_o <= 7'(tens_q) * 7'd10 + 7'(ones_q);
            win_o   <= state_q == WIN;
        end
    end
endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: directed self-checking bench, WIN_SCORE=21, BLINK_CYCLES=4.
module tb_score_bcd_counter;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam int TZ = 10;
`else
    localparam int TZ = 0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, inc = 1'b0, dec = 1'b0, clr = 1'b0;
    logic [3:0] tens, ones;
    logic [6:0] score;
    logic       win;
    int         checks = 0, errors = 0;

    score_bcd_counter #(.WIN_SCORE(21), .BLINK_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .inc_i(inc), .dec_i(dec), .clr_i(clr),
        .tens_o(tens), .ones_o(ones), .score_o(score), .win_o(win)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_inc(input int n = 1);
        repeat (n) begin
            inc = 1'b1;
            tick();
            inc = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_dec(input int n = 1);
        repeat (n) begin
            dec = 1'b1;
            tick();
            dec = 1'b0;
            tick();
        end
    endtask

    task automatic disp(input string tag, input int t, input int o);
        check({tag, "_tens"}, int'(tens), t);
        check({tag, "_ones"}, int'(ones), o);
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        disp("rst", TZ, 0);
        check("rst_score", int'(score), 0);
        check("rst_win", int'(win), 0);
        pulse_dec(3);
        check("dec_sat", int'(score), 0);
        disp("dec_sat", TZ, 0);

        pulse_inc(9);
        check("nine", int'(score), 9);
        disp("nine", TZ, 9);
        inc = 1'b1;
        tick();
        check("lat_pre", int'(score), 9);
        inc = 1'b0;
        tick();
        check("ten", int'(score), 10);
        disp("ten", 1, 0);

        inc = 1'b1;
        tick(20);
        inc = 1'b0;
        tick();
        check("held", int'(score), 11);
        inc = 1'b1;
        dec = 1'b1;
        tick();
        inc = 1'b0;
        dec = 1'b0;
        tick(2);
        check("both", int'(score), 11);

        pulse_inc(9);
        check("pre_win", int'(win), 0);
        pulse_inc(1);
        check("win", int'(win), 1);
        check("win_score", int'(score), 21);
        disp("blk0", 2, 1);
        tick(3);
        disp("blk0_end", 2, 1);
        tick();
        disp("blk1", 11, 10);
        tick(3);
        disp("blk1_end", 11, 10);
        tick();
        disp("blk2", 2, 1);
        pulse_inc(1);
        check("win_frozen", int'(score), 21);
        check("win_hold", int'(win), 1);

        pulse_dec(1);
        check("corr_win", int'(win), 0);
        check("corr_score", int'(score), 20);
        disp("corr", 2, 0);
        tick(5);
        disp("corr_steady", 2, 0);
        pulse_inc(1);
        check("rewin", int'(win), 1);
        disp("rewin0", 2, 1);
        tick(3);
        disp("rewin0_end", 2, 1);
        tick();
        disp("rewin1", 11, 10);

        rst_n = 1'b0;
        tick();
        check("midrst_win", int'(win), 0);
        check("midrst_score", int'(score), 0);
        disp("midrst", TZ, 0);
        rst_n = 1'b1;
        tick(2);
        disp("postrst", TZ, 0);

        pulse_inc(15);
        check("fifteen", int'(score), 15);
        disp("fifteen", 1, 5);
        inc = 1'b1;
        clr = 1'b1;
        tick();
        inc = 1'b0;
        clr = 1'b0;
        tick();
        check("clr_score", int'(score), 0);
        disp("clr", TZ, 0);
        check("clr_win", int'(win), 0);
        pulse_inc(21);
        check("win2", int'(win), 1);
        disp("win2", 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_bcd_counter.md
Name: score_bcd_counter

Overview:
Per-player score counter for the scoreboard. It turns single-cycle-wide button events (already debounced and synchronised upstream) into a saturating two-digit BCD score. It produces the tens/ones digit codes consumed directly by dual_7_seg (codes 0-9 = digits, 10 = blank, 11 = 'P'). On reaching the winning score it enters a WIN state and blinks the display between the score and "P ".

Parameters:
WIN_SCORE, 21, winning score; legal range 1..99.
BLINK_CYCLES, 5000000, clock cycles per blink half-period in WIN; legal range >= 2.

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_n_i  input  1  reset, synchronous, active-low
inc_i  input  1  increment request; acts on rising edge (low at previous sample, high now)
dec_i  input  1  decrement request; acts on rising edge
clr_i  input  1  synchronous clear, level-sensitive
tens_o  output  4  tens digit code to dual_7_seg tens_i
ones_o  output  4  ones digit code to dual_7_seg ones_i
score_o  output  7  binary score 0..99
win_o  output  1  high while in WIN state

Behaviour:
- Reset (rst_n_i low at clock edge): score tens=0, ones=0; state PLAY; blink counter=0; phase=0; edge registers=0. Outputs: ones_o=0, score_o=0, win_o=0, tens_o=10 if the macro is defined, else 0.
- Edge detect: inc_i and dec_i are registered each cycle. An event is current=1 and previous=0. A held-high input gives exactly one event.
- Priority per cycle: reset > clr_i > events.
- clr_i high: score=0, state PLAY, blink counter/phase=0. Events in the same cycle are discarded.
- Both inc and dec events in the same cycle: no change.
- PLAY, inc event:
  - ones 9->0 with tens+1; otherwise ones+1.
  - If the new score == WIN_SCORE, go to WIN with blink counter=0 and phase=0.
- PLAY, dec event:
  - At 00, saturate (no change).
  - Otherwise ones 0->9 with tens-1, else ones-1.
- WIN:
  - inc events are ignored (score frozen at WIN_SCORE).
  - A dec event decrements the score to WIN_SCORE-1 and returns to PLAY (correction path).
- Blink: in WIN, the counter runs 0..BLINK_CYCLES-1. At wrap it returns to 0 and phase toggles. In PLAY the counter and phase are held at 0.
- Display mapping, registered:
  - WIN, phase=1: tens_o=11, ones_o=10.
  - Otherwise: tens_o=tens digit, ones_o=ones digit (subject to the optional feature).
- score_o = tens*10+ones, registered with the digits. win_o registered from state.
- Latency:
  - Input edge present at clock edge k: internal score updates at k.
  - tens_o/ones_o/score_o/win_o update at k+1.
  - clr_i sampled at edge k: outputs show cleared values after k+1.
- Invariant: the digit registers never hold a value >9. Outputs 12..15 are never driven (dual_7_seg would show its error dash).
- Reset mid-WIN: immediate return to reset values at the next edge. No blink residue.

Optional Feature:
Macro SCORE_LEADING_ZERO_BLANK_EN.
- Defined: when the tens digit is 0 and the display is not in WIN phase 1, tens_o=10 (blank). Score 7 therefore shows " 7". Reset value of tens_o is 10.
- Undefined: tens_o always carries the tens digit ("07"). Reset value of tens_o is 0.
- score_o and win_o are unaffected either way.

Test Plan:
1. Reset low 3 cycles, then high -> tens_o=10 (macro on) / 0 (off), ones_o=0, score_o=0, win_o=0. Three dec pulses -> still 0.
2. Nine inc pulses, then one more -> ones_o=9 and tens blank/0, then tens_o=1, ones_o=0, score_o=10. Each update appears one cycle after the sampled edge.
3. inc held high 20 cycles -> score increments by exactly 1. inc and dec rising in the same cycle -> no change.
4. WIN_SCORE=21, BLINK_CYCLES=4: 21 inc pulses -> win_o=1, score_o=21. tens/ones alternate 2,1 / 11,10 every 4 cycles. A further inc -> still 21.
5. In WIN, one dec pulse -> win_o=0, score_o=20, display steady 2,0. An inc pulse re-enters WIN with phase 0 (shows 2,1 first).
6. Score 15, clr_i high for 1 cycle together with an inc edge -> score_o=0, tens_o=10/0, ones_o=0. Reset asserted during WIN -> reset values on the next edge.
